rr_arbiter_4_decoded: RTL and testbench

Four-requester round-robin arbiter that shares one resource and drives its one-hot grant through the team's 2-to-4 decoder with enable. Sits in front of any shared unit (bus port, memory bank, shared ALU) with four clients. Grants are held until the owner releases or a hold limit expires, with a one-cycle dead gap between owners so no two grants ever overlap.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_arbiter_4_decoded_if.sv | 22 ++
 rtl/decoder_2to4_with_enable.sv | 19 +
 rtl/rr_arbiter_4_decoded.sv | 105 ++++++++++
 tb/tb_rr_arbiter_4_decoded.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the four-way round-robin arbiter: requester count,
// index width and FSM state encoding.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // Requester index that follows i, wrapping 3 -> 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_4_decoded_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
interface rr_arbiter_4_decoded_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/decoder_2to4_with_enable.sv
// 2-to-4 one-hot decoder with active-high enable; a is the MSB of the select.
module decoder_2to4_with_enable (
  input  logic e,
  input  logic a,
  input  logic b,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  always_comb begin
    y0 = e & ~a & ~b;
    y1 = e & ~a &  b;
    y2 = e &  a & ~b;
    y3 = e &  a &  b;
  end

endmodule

// File: rtl/rr_arbiter_4_decoded.sv
// Four-requester round-robin arbiter with hold limit and a one-cycle dead gap
// between owners; the one-hot grant comes from the shared 2-to-4 decoder.
module rr_arbiter_4_decoded
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  rr_arbiter_4_decoded_if.slave   bus
);

  // state | meaning
  // IDLE  | no owner, arbitrating among requests
  // GRANT | gnt_idx owns the resource, hold counter running
  // GAP   | one dead cycle after a release, arbitrating with advanced pointer

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  logic [IDX_W:0]   pick;
  logic             owner_req;
  logic             at_limit;
  logic             release_now;
  logic [N_REQ-1:0] gnt_dec;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ...
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] c;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = p + IDX_W'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  always_comb begin
    pick        = rr_pick(bus.req, ptr);
    owner_req   = bus.req[idx];
    at_limit    = (cnt == LIMIT);
    release_now = bus.done | ~owner_req | at_limit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      valid     <= 1'b0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        GRANT: begin
          if (release_now) begin
            state     <= GAP;
            valid     <= 1'b0;
            ptr       <= next_idx(idx);
            // Only a pure hold-limit expiry counts as a revocation.
            timeout_q <= at_limit & ~bus.done & owner_req;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (pick[IDX_W]) begin
            state <= GRANT;
            idx   <= pick[IDX_W-1:0];
            cnt   <= '0;
            valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  decoder_2to4_with_enable u_dec (
    .e  (valid),
    .a  (idx[1]),
    .b  (idx[0]),
    .y0 (gnt_dec[0]),
    .y1 (gnt_dec[1]),
    .y2 (gnt_dec[2]),
    .y3 (gnt_dec[3])
  );

  assign bus.gnt       = gnt_dec;
  assign bus.gnt_idx   = idx;
  assign bus.gnt_valid = valid;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4_decoded.sv
// Bench for rr_arbiter_4_decoded: vector table, directed corner sequences and
// random traffic against a tenure-counting reference model.
module tb_rr_arbiter_4_decoded;
  import arb_pkg::*;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter_4_decoded_if bus ();

  rr_arbiter_4_decoded #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner number, tenure cycles so far (1-based), pointer.
  int m_owner, m_ptr, m_ten;
  bit m_valid, m_to;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       valid;
    logic       to;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_ptr = 0; m_ten = 0; m_valid = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    bit lim, rel;
    m_to = 0;
    if (m_valid) begin
      lim = (m_ten == MAX_HOLD);
      rel = d || !r[m_owner];
      if (rel || lim) begin
        m_to    = lim && !rel;
        m_valid = 0;
        m_ptr   = (m_owner + 1) % 4;
      end else begin
        m_ten++;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_valid = 1;
          m_ten   = 1;
          break;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " gnt"}, int'(bus.gnt), m_valid ? (1 << m_owner) : 0);
    chk({tag, " gnt_valid"}, int'(bus.gnt_valid), int'(m_valid));
    chk({tag, " gnt_idx"}, int'(bus.gnt_idx), m_owner);
    chk({tag, " timeout"}, int'(bus.timeout), int'(m_to));
  endtask

  task automatic step(input logic [3:0] r, input logic d, input string tag);
    bus.req  = r;
    bus.done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("reset gnt", int'(bus.gnt), 0);
    chk("reset gnt_valid", int'(bus.gnt_valid), 0);
    chk("reset gnt_idx", int'(bus.gnt_idx), 0);
    chk("reset timeout", int'(bus.timeout), 0);
    rst = 1'b0;
  endtask

  initial begin
    int starts[$];
    int tenures[$];
    int n_to, run;
    bit prev;
    logic [3:0] r;

    rst = 1'b1;
    bus.req = '0;
    bus.done = 1'b0;

    // Idle with no requests.
    do_reset();
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0, "idle");

    // req=0110, done after three grant cycles per owner.
    tbl[0] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd1};
    tbl[1] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd1};
    tbl[2] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd1};
    tbl[3] = '{4'b0110, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1};
    tbl[4] = '{4'b0110, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2};
    tbl[5] = '{4'b0110, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2};
    tbl[6] = '{4'b0110, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2};
    tbl[7] = '{4'b0110, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2};
    tbl[8] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.req  = tbl[i].req;
      bus.done = tbl[i].done;
      model_step(tbl[i].req, tbl[i].done);
      @(posedge clk);
      #1;
      chk("vec gnt", int'(bus.gnt), int'(tbl[i].gnt));
      chk("vec gnt_valid", int'(bus.gnt_valid), int'(tbl[i].valid));
      chk("vec timeout", int'(bus.timeout), int'(tbl[i].to));
      chk("vec gnt_idx", int'(bus.gnt_idx), int'(tbl[i].idx));
    end

    // All four requesting, never releasing: full rotation by hold limit.
    do_reset();
    n_to = 0; run = 0; prev = 0;
    for (int c = 0; c < 60 && starts.size() < 5; c++) begin
      step(4'b1111, 1'b0, "rot");
      if (bus.gnt_valid && !prev) starts.push_back(int'(bus.gnt_idx));
      if (bus.gnt_valid) run++;
      else if (prev) begin
        tenures.push_back(run);
        run = 0;
      end
      if (bus.timeout) n_to++;
      prev = bus.gnt_valid;
    end
    chk("rot starts", starts.size(), 5);
    for (int i = 0; i < starts.size() && i < 5; i++) chk("rot order", starts[i], i % 4);
    chk("rot tenures", tenures.size(), 4);
    foreach (tenures[i]) chk("rot tenure len", tenures[i], MAX_HOLD);
    chk("rot timeouts", n_to, 4);

    // Owner 2 drops its request in its third cycle while 3 is waiting.
    do_reset();
    step(4'b0100, 1'b0, "drop");
    step(4'b1100, 1'b0, "drop");
    step(4'b1100, 1'b0, "drop");
    step(4'b1000, 1'b0, "drop");
    chk("drop gap gnt", int'(bus.gnt), 0);
    chk("drop gap timeout", int'(bus.timeout), 0);
    step(4'b1000, 1'b0, "drop");
    chk("drop next gnt", int'(bus.gnt), 4'b1000);

    // done on the same edge as the hold limit: no timeout.
    do_reset();
    for (int i = 0; i < MAX_HOLD; i++) step(4'b0001, 1'b0, "lim");
    step(4'b0001, 1'b1, "lim");
    chk("lim done gnt", int'(bus.gnt), 0);
    chk("lim done timeout", int'(bus.timeout), 0);
    step(4'b0001, 1'b0, "lim");
    chk("lim regrant gnt", int'(bus.gnt), 4'b0001);

    // Asynchronous reset during requester 3's grant.
    do_reset();
    step(4'b1010, 1'b0, "arst");
    step(4'b1010, 1'b1, "arst");
    step(4'b1010, 1'b0, "arst");
    chk("arst owner", int'(bus.gnt), 4'b1000);
    step(4'b1010, 1'b0, "arst");
    #2 rst = 1'b1;
    #1;
    chk("arst gnt", int'(bus.gnt), 0);
    chk("arst gnt_valid", int'(bus.gnt_valid), 0);
    chk("arst timeout", int'(bus.timeout), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b1010, 1'b0, "arst");
    chk("arst first gnt", int'(bus.gnt), 4'b0010);

    // Random traffic with sticky requests so hold limits are reached.
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 11) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
